// File: rtl/pe_operand_packer_pkg.sv
// pe_pkg: shared sizing, PE opcodes and the packer FSM state type.
//   DP         coefficients per operand vector (PE count)
//   DATA_WIDTH coefficient width in bits
//   LANES      coefficients per input beat
//   BEATS      beats per operand vector (DP / LANES)
package pe_pkg;
  localparam int DP         = 256;
  localparam int DATA_WIDTH = 54;
  localparam int LANES      = 16;
  localparam int BEATS      = DP / LANES;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] PE_OP_NOP = 2'd0;
  localparam logic [1:0] PE_OP_ADD = 2'd1;
  localparam logic [1:0] PE_OP_MUL = 2'd2;
  localparam logic [1:0] PE_OP_MAC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } pe_state_e;
endpackage

// File: rtl/pe_operand_packer_bank.sv
// pe_operand_bank: one DP-coefficient staging bank.
//   clk, rst   clock, synchronous active-low reset
//   clr        zero the whole bank (start of a command)
//   we         write wdata into the beat slot selected by beat_idx
//   beat_idx   beat slot, coefficients [beat_idx*LANES +: LANES]
//   wdata      LANES coefficients of one beat
//   modulus    range bound (only with PE_PACK_RANGE_CHECK_EN)
//   data       staged vector
//   range_hit  some lane of the beat written this cycle is >= modulus
// Build option: PE_PACK_RANGE_CHECK_EN enables the lane comparators.
module pe_operand_bank
  import pe_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        we,
  input  logic [BEAT_W-1:0]           beat_idx,
  input  logic [LANES*DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0]       modulus,
  output logic [DP*DATA_WIDTH-1:0]    data,
  output logic                        range_hit
);
  logic [DP*DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr)
      data_d = '0;
    else if (we)
      data_d[int'(beat_idx)*LANES*DATA_WIDTH +: LANES*DATA_WIDTH] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign data = data_q;

`ifdef PE_PACK_RANGE_CHECK_EN
  always_comb begin
    range_hit = 1'b0;
    for (int j = 0; j < LANES; j++)
      if (we && (wdata[j*DATA_WIDTH +: DATA_WIDTH] >= modulus))
        range_hit = 1'b1;
  end
`else
  logic unused_modulus;
  assign unused_modulus = ^modulus;
  assign range_hit      = 1'b0;
`endif
endmodule

// File: rtl/pe_operand_packer.sv
// pe_operand_packer: gathers LANES-wide coefficient beats into up to three
// DP-wide operand vectors and hands them, with an opcode, to the PE array.
//   clk, rst            clock, synchronous active-low reset
//   cmd_*               command handshake (opcode, operand count 1..3, 0 -> 1)
//   in_valid/ready/data coefficient beat stream
//   modulus             range bound (only with PE_PACK_RANGE_CHECK_EN)
//   out_valid/ready     vector set handshake
//   ctrl_pe             opcode of the presented set
//   input_data0..2      presented operand vectors
//   err_range           sticky range error
// Build option: PE_PACK_RANGE_CHECK_EN (see pe_operand_bank).
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready=1)
// FILL  | accepting beats into the staging banks (in_ready=1)
// DONE  | staging complete, waiting for the output register to be free
module pe_operand_packer
  import pe_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_ctrl_pe,
  input  logic [1:0]                  cmd_num_ops,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]       modulus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  ctrl_pe,
  output logic [DP*DATA_WIDTH-1:0]    input_data0,
  output logic [DP*DATA_WIDTH-1:0]    input_data1,
  output logic [DP*DATA_WIDTH-1:0]    input_data2,
  output logic                        err_range
);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  pe_state_e                state_q, state_d;
  logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]               op_cnt_q, op_cnt_d;
  logic [1:0]               num_ops_q, num_ops_d;
  logic [1:0]               ctrl_stage_q, ctrl_stage_d;
  logic                     out_valid_q, out_valid_d;
  logic [1:0]               ctrl_pe_q, ctrl_pe_d;
  logic [DP*DATA_WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
  logic                     err_range_q, err_range_d;

  logic                     cmd_fire, in_fire, last_beat, xfer;
  logic [2:0]               bank_we, bank_hit;
  logic [DP*DATA_WIDTH-1:0] stage_data [3];

  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == FILL);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_beat = (beat_cnt_q == BEAT_LAST) && (op_cnt_q == num_ops_q - 2'd1);
  // The output register is free when empty or being drained this cycle.
  assign xfer      = (state_q == DONE) && (!out_valid_q || out_ready);

  for (genvar k = 0; k < 3; k++) begin : g_bank
    assign bank_we[k] = in_fire && (op_cnt_q == 2'(k));
    pe_operand_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .clr       (cmd_fire),
      .we        (bank_we[k]),
      .beat_idx  (beat_cnt_q),
      .wdata     (in_data),
      .modulus   (modulus),
      .data      (stage_data[k]),
      .range_hit (bank_hit[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    op_cnt_d     = op_cnt_q;
    num_ops_d    = num_ops_q;
    ctrl_stage_d = ctrl_stage_q;
    out_valid_d  = out_valid_q;
    ctrl_pe_d    = ctrl_pe_q;
    out0_d       = out0_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    err_range_d  = err_range_q | (|bank_hit);

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d      = FILL;
          ctrl_stage_d = cmd_ctrl_pe;
          num_ops_d    = (cmd_num_ops == 2'd0) ? 2'd1 : cmd_num_ops;
          beat_cnt_d   = '0;
          op_cnt_d     = '0;
        end
      end
      FILL: begin
        if (in_fire) begin
          if (last_beat) begin
            state_d    = DONE;
            beat_cnt_d = '0;
            op_cnt_d   = '0;
          end else if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            op_cnt_d   = op_cnt_q + 2'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A transfer overrides a same-cycle handshake so out_valid stays high.
    if (xfer) begin
      out_valid_d = 1'b1;
      ctrl_pe_d   = ctrl_stage_q;
      out0_d      = stage_data[0];
      out1_d      = stage_data[1];
      out2_d      = stage_data[2];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      op_cnt_q     <= '0;
      num_ops_q    <= 2'd1;
      ctrl_stage_q <= PE_OP_NOP;
      out_valid_q  <= 1'b0;
      ctrl_pe_q    <= PE_OP_NOP;
      out0_q       <= '0;
      out1_q       <= '0;
      out2_q       <= '0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      op_cnt_q     <= op_cnt_d;
      num_ops_q    <= num_ops_d;
      ctrl_stage_q <= ctrl_stage_d;
      out_valid_q  <= out_valid_d;
      ctrl_pe_q    <= ctrl_pe_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      err_range_q  <= err_range_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign ctrl_pe     = ctrl_pe_q;
  assign input_data0 = out0_q;
  assign input_data1 = out1_q;
  assign input_data2 = out2_q;
  assign err_range   = err_range_q;
endmodule

// File: tb/tb_pe_operand_packer.sv
module tb_pe_operand_packer;
  import pe_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int VW = DP * DW;
`ifdef PE_PACK_RANGE_CHECK_EN
  localparam int RC = 1;
`else
  localparam int RC = 0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid, cmd_ready;
  logic [1:0]          cmd_ctrl_pe, cmd_num_ops;
  logic                in_valid, in_ready;
  logic [LANES*DW-1:0] in_data;
  logic [DW-1:0]       modulus;
  logic                out_valid, out_ready;
  logic [1:0]          ctrl_pe;
  logic [VW-1:0]       input_data0, input_data1, input_data2;
  logic                err_range;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_operand_packer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl_pe(cmd_ctrl_pe), .cmd_num_ops(cmd_num_ops),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_pe(ctrl_pe),
    .input_data0(input_data0), .input_data1(input_data1), .input_data2(input_data2),
    .err_range(err_range)
  );

  typedef struct {
    logic [1:0] num_ops;
    logic [1:0] ctrl;
    int         gap;
    int         tag;
    int         exp_loaded;
  } vec_t;

  vec_t tbl [5];

  // mode 0: (tag<<40)|(op<<20)|index; mode 1: small values with coeff 37 = 97
  function automatic logic [DW-1:0] exp_coeff(int k, int i, int loaded, int tag, int mode);
    longint v;
    if (k >= loaded) return '0;
    if (mode == 0) v = (longint'(tag) << 40) | (longint'(k) << 20) | longint'(i);
    else           v = (i == 37) ? 97 : (i % 50);
    return DW'(v);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_op(input string name, input int k, input logic [VW-1:0] act,
                          input int loaded, input int tag, input int mode);
    int bad;
    int first;
    bad = 0;
    first = 0;
    for (int i = 0; i < DP; i++)
      if (act[i*DW +: DW] !== exp_coeff(k, i, loaded, tag, mode)) begin
        if (bad == 0) first = i;
        bad++;
      end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: %0d coeffs wrong, first [%0d] got %h required %h", name, bad,
               first, act[first*DW +: DW], exp_coeff(k, first, loaded, tag, mode));
    end
  endtask

  task automatic check_all(input string name, input int loaded, input int tag, input int mode);
    check_op({name, "_op0"}, 0, input_data0, loaded, tag, mode);
    check_op({name, "_op1"}, 1, input_data1, loaded, tag, mode);
    check_op({name, "_op2"}, 2, input_data2, loaded, tag, mode);
  endtask

  task automatic send_cmd(input logic [1:0] ops, input logic [1:0] ctrl);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_wait: cmd_ready got %b required 1", cmd_ready);
    end
    cmd_valid   = 1'b1;
    cmd_num_ops = ops;
    cmd_ctrl_pe = ctrl;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Sends nmax beats at most; returns at the falling edge after the last accept.
  task automatic send_beats(input int nops, input int tag, input int mode, input int gap,
                            input int nmax);
    int n;
    int sent;
    sent = 0;
    for (int op = 0; op < nops; op++)
      for (int b = 0; b < BEATS; b++) begin
        if (sent < nmax) begin
          if (gap > 0 && sent > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
          for (int j = 0; j < LANES; j++)
            in_data[j*DW +: DW] = exp_coeff(op, b*LANES + j, nops, tag, mode);
          in_valid = 1'b1;
          n = 0;
          while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
          if (in_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_wait: in_ready got %b required 1 (op %0d beat %0d)", in_ready, op, b);
          end
          @(negedge clk);
          in_valid = 1'b0;
          sent++;
        end
      end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd3, PE_OP_ADD, 0, 1, 3};
    tbl[1] = '{2'd2, PE_OP_MUL, 0, 2, 2};
    tbl[2] = '{2'd0, PE_OP_MAC, 0, 3, 1};
    tbl[3] = '{2'd3, PE_OP_ADD, 3, 1, 3};
    tbl[4] = '{2'd1, PE_OP_NOP, 1, 4, 1};

    rst = 1'b0; cmd_valid = 1'b0; cmd_ctrl_pe = '0; cmd_num_ops = '0;
    in_valid = 1'b0; in_data = '0; modulus = '1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctrl_pe", ctrl_pe, 0);
    chk("rst_err_range", err_range, 0);
    check_all("rst", 0, 0, 0);

    for (int v = 0; v < 5; v++) begin
      send_cmd(tbl[v].num_ops, tbl[v].ctrl);
      send_beats(tbl[v].exp_loaded, tbl[v].tag, 0, tbl[v].gap, 1000);
      chk($sformatf("v%0d_in_ready_done", v), in_ready, 0);
      chk($sformatf("v%0d_out_valid_early", v), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", v), out_valid, 1);
      chk($sformatf("v%0d_ctrl_pe", v), ctrl_pe, tbl[v].ctrl);
      check_all($sformatf("v%0d", v), tbl[v].exp_loaded, tbl[v].tag, 0);
    end

    // reset in the middle of a fill
    @(negedge clk);
    send_cmd(2'd3, PE_OP_MUL);
    send_beats(3, 8, 0, 0, 5);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    send_cmd(2'd1, PE_OP_MUL);
    send_beats(1, 9, 0, 0, 1000);
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_ctrl_pe", ctrl_pe, PE_OP_MUL);
    check_all("post_rst", 1, 9, 0);

    // backpressure: second set parks in DONE behind the held first set
    @(negedge clk);
    out_ready = 1'b0;
    send_cmd(2'd1, PE_OP_MAC);
    send_beats(1, 5, 0, 0, 1000);
    @(negedge clk);
    chk("bp_a_out_valid", out_valid, 1);
    check_op("bp_a_op0", 0, input_data0, 1, 5, 0);
    send_cmd(2'd2, PE_OP_ADD);
    send_beats(2, 6, 0, 1, 1000);
    repeat (3) @(negedge clk);
    chk("bp_park_in_ready", in_ready, 0);
    chk("bp_park_cmd_ready", cmd_ready, 0);
    chk("bp_hold_out_valid", out_valid, 1);
    chk("bp_hold_ctrl_pe", ctrl_pe, PE_OP_MAC);
    check_op("bp_hold_op0", 0, input_data0, 1, 5, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_out_valid", out_valid, 1);
    chk("bp_b_ctrl_pe", ctrl_pe, PE_OP_ADD);
    check_all("bp_b", 2, 6, 0);
    @(negedge clk);
    chk("bp_drained_out_valid", out_valid, 0);

    // range check: coefficient 37 (beat 2, lane 5) equals the modulus
    modulus = DW'(97);
    send_cmd(2'd1, PE_OP_NOP);
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < LANES; j++)
        in_data[j*DW +: DW] = exp_coeff(0, b*LANES + j, 1, 0, 1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (b == 1) chk("rc_err_before", err_range, 0);
      if (b == 2) chk("rc_err_after_hit", err_range, RC);
      if (b == BEATS - 1) chk("rc_err_sticky", err_range, RC);
    end
    @(negedge clk);
    chk("rc_out_valid", out_valid, 1);
    check_all("rc_data", 1, 0, 1);
    repeat (2) @(negedge clk);
    chk("rc_err_held", err_range, RC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
